// File: rtl/pll_lock_sequencer.sv
// Reset/lock sequencer for the 100 MHz PLL wrapper: holds the PLL in reset, waits for a
// stable synchronised lock, then releases the downstream system reset; retries and faults on timeout.
module pll_lock_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT       = 100000,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned MAX_RETRIES        = 3
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst_n,
  output logic       fault,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic [2:0] state
);

  localparam int unsigned CNT_MAX_A = (RST_HOLD_CYCLES > LOCK_TIMEOUT) ? RST_HOLD_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_HOLD      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_t;

  state_t           st;
  logic [1:0]       sync_q;
  logic             lk;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       retry_inc;

  assign lk        = sync_q[1];
  assign retry_inc = retry_cnt + 4'd1;
  assign state     = st;

  // One shared dwell counter: every state that times something clears it on entry.
  // Outputs are registered alongside the state, so they track each transition on the same edge.
  always_ff @(posedge refclk) begin
    if (!rst_n) begin
      sync_q    <= '0;
      st        <= S_HOLD;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
      if (restart) begin
        st        <= S_HOLD;
        cnt       <= '0;
        pll_rst   <= 1'b1;
        sys_rst_n <= 1'b0;
        fault     <= 1'b0;
        retry_cnt <= '0;
      end else begin
        case (st)
          S_HOLD: begin
            if (cnt == HOLD_LAST) begin
              st      <= S_WAIT_LOCK;
              cnt     <= '0;
              pll_rst <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (lk) begin
              st  <= S_STABLE;
              cnt <= '0;
            end else if (cnt == TIMEOUT_LAST) begin
              retry_cnt <= retry_inc;
              cnt       <= '0;
              pll_rst   <= 1'b1;
              if (retry_inc == RETRY_LIMIT) begin
                st    <= S_FAULT;
                fault <= 1'b1;
              end else begin
                st <= S_HOLD;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_STABLE: begin
            if (!lk) begin
              retry_cnt <= retry_inc;
              cnt       <= '0;
              pll_rst   <= 1'b1;
              if (retry_inc == RETRY_LIMIT) begin
                st    <= S_FAULT;
                fault <= 1'b1;
              end else begin
                st <= S_HOLD;
              end
            end else if (cnt == STABLE_LAST) begin
              st        <= S_RUN;
              cnt       <= '0;
              sys_rst_n <= 1'b1;
              retry_cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RUN: begin
            if (!lk) begin
              st        <= S_HOLD;
              cnt       <= '0;
              pll_rst   <= 1'b1;
              sys_rst_n <= 1'b0;
              if (loss_cnt != '1) loss_cnt <= loss_cnt + 8'd1;
            end
          end
          S_FAULT: begin
            cnt <= '0;
          end
          default: begin
            st        <= S_HOLD;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            fault     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short hold/timeout/stable parameters;
// expected values are hand-derived cycle positions relative to the stimulus edges.
module tb_pll_lock_sequencer;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst_n;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;
  logic [2:0] state;

  int vectors = 0;
  int miscompares = 0;

  pll_lock_sequencer #(
    .RST_HOLD_CYCLES   (4),
    .LOCK_TIMEOUT      (20),
    .LOCK_STABLE_CYCLES(8),
    .MAX_RETRIES       (3)
  ) dut (
    .refclk    (refclk),
    .rst_n     (rst_n),
    .pll_locked(pll_locked),
    .restart   (restart),
    .pll_rst   (pll_rst),
    .sys_rst_n (sys_rst_n),
    .fault     (fault),
    .retry_cnt (retry_cnt),
    .loss_cnt  (loss_cnt),
    .state     (state)
  );

  always #5 refclk = ~refclk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge refclk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".state"}, 32'(state), 0);
    check({tag, ".pll_rst"}, 32'(pll_rst), 1);
    check({tag, ".sys_rst_n"}, 32'(sys_rst_n), 0);
    check({tag, ".fault"}, 32'(fault), 0);
    check({tag, ".retry"}, 32'(retry_cnt), 0);
    check({tag, ".loss"}, 32'(loss_cnt), 0);
  endtask

  initial begin
    int exp_loss;
    rst_n = 1'b0;
    pll_locked = 1'b0;
    restart = 1'b0;
    tick(3);
    check_reset_values("reset");

    // Nominal start
    rst_n = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check("nom.hold_pll_rst", 32'(pll_rst), 1);
    end
    tick();
    check("nom.pll_rst_release", 32'(pll_rst), 0);
    check("nom.wait_state", 32'(state), 1);
    tick(6);
    pll_locked = 1'b1;
    tick(3);
    check("nom.stable_state", 32'(state), 2);
    tick(7);
    check("nom.sys_rst_pre", 32'(sys_rst_n), 0);
    tick();
    check("nom.sys_rst_rise", 32'(sys_rst_n), 1);
    check("nom.run_state", 32'(state), 3);
    check("nom.retry", 32'(retry_cnt), 0);

    // Restart from RUN, then a glitchy lock
    restart = 1'b1;
    pll_locked = 1'b0;
    tick();
    restart = 1'b0;
    check("rst_run.state", 32'(state), 0);
    check("rst_run.pll_rst", 32'(pll_rst), 1);
    check("rst_run.sys_rst_n", 32'(sys_rst_n), 0);
    tick(4);
    check("glitch.wait", 32'(state), 1);
    pll_locked = 1'b1;
    tick(3);
    check("glitch.stable", 32'(state), 2);
    tick(2);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick(2);
    check("glitch.fail_state", 32'(state), 0);
    check("glitch.retry1", 32'(retry_cnt), 1);
    check("glitch.pll_rst", 32'(pll_rst), 1);
    tick(3);
    check("glitch.hold_end", 32'(pll_rst), 1);
    tick();
    check("glitch.pll_rst_rel", 32'(pll_rst), 0);
    tick();
    check("glitch.stable2", 32'(state), 2);
    tick(7);
    check("glitch.stable2_retry", 32'(retry_cnt), 1);
    tick();
    check("glitch.run", 32'(state), 3);
    check("glitch.retry_clr", 32'(retry_cnt), 0);
    check("glitch.sys_rst_n", 32'(sys_rst_n), 1);

    // Exhausted retries
    restart = 1'b1;
    pll_locked = 1'b0;
    tick();
    restart = 1'b0;
    tick(4);
    check("exh.wait1", 32'(state), 1);
    tick(19);
    check("exh.wait1_last", 32'(state), 1);
    tick();
    check("exh.to1_state", 32'(state), 0);
    check("exh.to1_retry", 32'(retry_cnt), 1);
    tick(4);
    tick(19);
    check("exh.wait2_last", 32'(state), 1);
    tick();
    check("exh.to2_retry", 32'(retry_cnt), 2);
    tick(4);
    tick(19);
    check("exh.wait3_last", 32'(state), 1);
    tick();
    check("exh.fault_state", 32'(state), 4);
    check("exh.fault", 32'(fault), 1);
    check("exh.pll_rst", 32'(pll_rst), 1);
    check("exh.retry3", 32'(retry_cnt), 3);
    check("exh.sys_rst_n", 32'(sys_rst_n), 0);
    for (int c = 0; c < 200; c++) begin
      tick();
      check("exh.fault_hold", 32'(state), 4);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("exh.restart_state", 32'(state), 0);
    check("exh.restart_fault", 32'(fault), 0);
    check("exh.restart_retry", 32'(retry_cnt), 0);
    check("exh.restart_pll_rst", 32'(pll_rst), 1);

    // Timeout boundary: one failed attempt, then lock lands on the last timeout cycle
    tick(4);
    tick(20);
    check("bnd.first_fail", 32'(retry_cnt), 1);
    tick(4);
    check("bnd.wait", 32'(state), 1);
    tick(17);
    pll_locked = 1'b1;
    tick(2);
    check("bnd.pre_state", 32'(state), 1);
    tick();
    check("bnd.lock_wins", 32'(state), 2);
    check("bnd.retry_kept", 32'(retry_cnt), 1);
    tick(8);
    check("bnd.run", 32'(state), 3);
    check("bnd.retry_clr", 32'(retry_cnt), 0);

    // Lock loss in RUN, then saturation of loss_cnt
    pll_locked = 1'b0;
    tick(2);
    check("loss.still_run", 32'(sys_rst_n), 1);
    tick();
    check("loss.sys_rst_n", 32'(sys_rst_n), 0);
    check("loss.pll_rst", 32'(pll_rst), 1);
    check("loss.state", 32'(state), 0);
    check("loss.cnt1", 32'(loss_cnt), 1);
    check("loss.retry", 32'(retry_cnt), 0);
    pll_locked = 1'b1;
    tick(13);
    check("loss.relock", 32'(state), 3);
    for (int i = 2; i <= 300; i++) begin
      exp_loss = (i > 255) ? 255 : i;
      pll_locked = 1'b0;
      tick(3);
      check("loss.rep_cnt", 32'(loss_cnt), 32'(exp_loss));
      check("loss.rep_sys", 32'(sys_rst_n), 0);
      pll_locked = 1'b1;
      tick(13);
      check("loss.rep_run", 32'(state), 3);
    end

    // Mid-operation reset in STABLE
    pll_locked = 1'b0;
    tick(3);
    check("mid.loss_sat", 32'(loss_cnt), 255);
    pll_locked = 1'b1;
    tick(5);
    check("mid.in_stable", 32'(state), 2);
    rst_n = 1'b0;
    tick();
    check_reset_values("mid_stable");
    rst_n = 1'b1;
    tick(13);
    check("mid.relock", 32'(state), 3);

    // Mid-operation reset in RUN, with a nonzero loss count beforehand
    pll_locked = 1'b0;
    tick(3);
    check("mid.loss1", 32'(loss_cnt), 1);
    pll_locked = 1'b1;
    tick(13);
    check("mid.run2", 32'(state), 3);
    check("mid.run2_sys", 32'(sys_rst_n), 1);
    rst_n = 1'b0;
    tick();
    check_reset_values("mid_run");
    rst_n = 1'b1;
    tick();
    check("mid.after_rel", 32'(state), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
